// File: rtl/tensor_core_gemm_ctrl.sv
// rtl/tensor_core_gemm_ctrl.sv - K-loop sequencer for a 4x4 tensor-core GEMM tile accumulator
// Walks k_tiles A/B fetches, issues one accumulate per tile, then holds the result until accepted.
module tensor_core_gemm_ctrl #(
  parameter int KT_WIDTH   = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [KT_WIDTH-1:0]   k_tiles,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] a_stride,
  input  logic [ADDR_WIDTH-1:0] b_stride,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_a_addr,
  output logic [ADDR_WIDTH-1:0] fetch_b_addr,
  input  logic                  fetch_ack,
  output logic                  mma_c_valid,
  output logic                  acc_we,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [KT_WIDTH-1:0] KT_ONE = KT_WIDTH'(1);

  logic [1:0]            state;
  logic [KT_WIDTH-1:0]   k_tiles_q;
  logic [KT_WIDTH-1:0]   k_idx;
  logic [ADDR_WIDTH-1:0] a_stride_q;
  logic [ADDR_WIDTH-1:0] b_stride_q;
  logic                  last_tile;

  // k_tiles_q is never zero once a job runs, so the subtraction cannot underflow
  assign last_tile = (k_idx == (k_tiles_q - KT_ONE));

  // abort masks every strobe in the cycle it arrives so nothing downstream acts on it
  assign fetch_req    = (state == S_FETCH) && !abort;
  assign acc_we       = (state == S_MAC) && !abort;
  assign mma_c_valid  = acc_we && (k_idx != '0);
  assign result_valid = (state == S_OUT) && !abort;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k_tiles_q    <= '0;
      k_idx        <= '0;
      a_stride_q   <= '0;
      b_stride_q   <= '0;
      fetch_a_addr <= '0;
      fetch_b_addr <= '0;
      done         <= 1'b0;
      err_zero     <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_zero <= 1'b0;
      if (abort) begin
        state        <= S_IDLE;
        k_idx        <= '0;
        fetch_a_addr <= '0;
        fetch_b_addr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              k_tiles_q    <= k_tiles;
              a_stride_q   <= a_stride;
              b_stride_q   <= b_stride;
              k_idx        <= '0;
              fetch_a_addr <= a_base;
              fetch_b_addr <= b_base;
              if (k_tiles == '0) begin
                done     <= 1'b1;
                err_zero <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (fetch_ack) begin
              state <= S_MAC;
            end
          end
          S_MAC: begin
            if (last_tile) begin
              state <= S_OUT;
            end else begin
              k_idx        <= k_idx + KT_ONE;
              fetch_a_addr <= fetch_a_addr + a_stride_q;
              fetch_b_addr <= fetch_b_addr + b_stride_q;
              state        <= S_FETCH;
            end
          end
          S_OUT: begin
            if (result_ready) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tensor_core_gemm_ctrl.sv
// tb/tb_tensor_core_gemm_ctrl.sv - scoreboard bench for tensor_core_gemm_ctrl
// Jobs push expected accumulate/done events; a negedge monitor pops and compares them.
module tb_tensor_core_gemm_ctrl;

  localparam int KW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] k_tiles = '0;
  logic [AW-1:0] a_base = '0;
  logic [AW-1:0] b_base = '0;
  logic [AW-1:0] a_stride = '0;
  logic [AW-1:0] b_stride = '0;
  logic          fetch_ack = 1'b0;
  logic          result_ready = 1'b0;
  logic          fetch_req;
  logic [AW-1:0] fetch_a_addr;
  logic [AW-1:0] fetch_b_addr;
  logic          mma_c_valid;
  logic          acc_we;
  logic          result_valid;
  logic          busy;
  logic          done;
  logic          err_zero;

  tensor_core_gemm_ctrl #(.KT_WIDTH(KW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_tiles(k_tiles),
    .a_base(a_base), .b_base(b_base), .a_stride(a_stride), .b_stride(b_stride),
    .fetch_req(fetch_req), .fetch_a_addr(fetch_a_addr), .fetch_b_addr(fetch_b_addr),
    .fetch_ack(fetch_ack), .mma_c_valid(mma_c_valid), .acc_we(acc_we),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy),
    .done(done), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int cv;
    int c;
  } mac_t;

  typedef struct {
    int err;
    int c;
  } done_t;

  mac_t  mac_q[$];
  done_t done_q[$];

  int compared = 0;
  int mismatched = 0;
  int exp_rv_cyc = -1;
  int last_t0 = 0;
  int ack_mode = 0;   // 0 tied high, 1 random, 2 after three wait cycles
  int rdy_mode = 0;   // 0 tied high, 1 random, 2 manual
  bit rdy_manual = 1'b0;
  bit noise = 1'b0;
  int wcnt = 0;

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: actual=event required=none (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) begin
    #2;
    if (fetch_req) wcnt++;
    else wcnt = 0;
    case (ack_mode)
      0:       fetch_ack = 1'b1;
      1:       fetch_ack = ($urandom % 3 == 0);
      default: fetch_ack = (wcnt > 3);
    endcase
    case (rdy_mode)
      0:       result_ready = 1'b1;
      1:       result_ready = ($urandom % 3 == 0);
      default: result_ready = rdy_manual;
    endcase
  end

  always @(negedge clk) begin : mon
    mac_t  e;
    done_t d;
    logic          p_freq, p_ack, p_abort, p_rv, p_rr;
    logic [AW-1:0] p_a, p_b;
    if (!rst_n) begin
      p_freq = 1'b0; p_ack = 1'b0; p_abort = 1'b0; p_rv = 1'b0; p_rr = 1'b0;
      p_a = '0; p_b = '0;
    end else begin
      if (acc_we) begin
        if (mac_q.size() == 0) flag("unexpected_acc_we");
        else begin
          e = mac_q.pop_front();
          chk("mac_a_addr", int'(fetch_a_addr), e.a);
          chk("mac_b_addr", int'(fetch_b_addr), e.b);
          chk("mma_c_valid", int'(mma_c_valid), e.cv);
          if (e.c >= 0) chk("mac_cycle", cyc, e.c);
        end
      end else if (mma_c_valid) flag("c_valid_outside_mac");
      if (fetch_req) begin
        if (mac_q.size() == 0) flag("unexpected_fetch_req");
        else begin
          chk("fetch_a_addr", int'(fetch_a_addr), mac_q[0].a);
          chk("fetch_b_addr", int'(fetch_b_addr), mac_q[0].b);
        end
      end
      if (p_freq && !p_ack && !p_abort) begin
        chk("fetch_req_held", int'(fetch_req), 1);
        chk("fetch_a_stable", int'(fetch_a_addr), int'(p_a));
        chk("fetch_b_stable", int'(fetch_b_addr), int'(p_b));
      end
      if (p_rv && !p_rr && !p_abort) chk("result_valid_held", int'(result_valid), 1);
      if (result_valid && !p_rv && exp_rv_cyc >= 0) chk("result_valid_cycle", cyc, exp_rv_cyc);
      if (done) begin
        if (done_q.size() == 0) flag("unexpected_done");
        else begin
          d = done_q.pop_front();
          chk("err_zero", int'(err_zero), d.err);
          if (d.c >= 0) chk("done_cycle", cyc, d.c);
          if (d.err == 0) chk("done_after_handshake", int'(p_rv && p_rr && !p_abort), 1);
        end
      end else if (err_zero) flag("err_zero_without_done");
      p_freq = fetch_req; p_ack = fetch_ack; p_abort = abort;
      p_rv = result_valid; p_rr = result_ready;
      p_a = fetch_a_addr; p_b = fetch_b_addr;
    end
  end

  task automatic start_job(int kt, int ab, int bb, int as_, int bs, bit tied);
    int n = 0;
    mac_t  e;
    done_t d;
    @(posedge clk); #1;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) flag("busy_timeout");
    start = 1'b1;
    k_tiles = KW'(kt);
    a_base = AW'(ab); b_base = AW'(bb);
    a_stride = AW'(as_); b_stride = AW'(bs);
    last_t0 = cyc;
    for (int k = 0; k < kt; k++) begin
      e.a  = (ab + k * as_) % (1 << AW);
      e.b  = (bb + k * bs) % (1 << AW);
      e.cv = (k != 0) ? 1 : 0;
      e.c  = tied ? last_t0 + 2 + 2 * k : -1;
      mac_q.push_back(e);
    end
    d.err = (kt == 0) ? 1 : 0;
    d.c   = !tied ? -1 : (kt == 0) ? last_t0 + 1 : last_t0 + 2 * kt + 2;
    done_q.push_back(d);
    exp_rv_cyc = (tied && kt != 0) ? last_t0 + 2 * kt + 1 : -1;
    @(posedge clk); #1;
    start = 1'b0;
    k_tiles = KW'($urandom);
    a_base = AW'($urandom); b_base = AW'($urandom);
    a_stride = AW'($urandom); b_stride = AW'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((mac_q.size() != 0 || done_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      start = noise && busy && ($urandom % 4 == 0);
      k_tiles = KW'($urandom);
      a_base = AW'($urandom);
      n++;
    end
    start = 1'b0;
    if (mac_q.size() != 0 || done_q.size() != 0) begin
      flag("job_timeout");
      mac_q.delete();
      done_q.delete();
    end
    exp_rv_cyc = -1;
  endtask

  task automatic run_job(int kt, int ab, int bb, int as_, int bs, bit tied);
    start_job(kt, ab, bb, as_, bs, tied);
    wait_done();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_fetch_req"}, int'(fetch_req), 0);
    chk({tag, "_fetch_a_addr"}, int'(fetch_a_addr), 0);
    chk({tag, "_fetch_b_addr"}, int'(fetch_b_addr), 0);
    chk({tag, "_acc_we"}, int'(acc_we), 0);
    chk({tag, "_mma_c_valid"}, int'(mma_c_valid), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err_zero"}, int'(err_zero), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // three tiles, back-to-back handshakes
    run_job(3, 'h010, 'h200, 4, 8, 1'b1);

    // three-cycle fetch latency
    ack_mode = 2;
    run_job(2, 'h040, 'h100, 'h20, 'h10, 1'b0);
    ack_mode = 0;

    // zero tiles: error pulse, no fetch, never busy
    start_job(0, 'h123, 'h045, 1, 1, 1'b1);
    repeat (4) begin
      chk("zero_busy", int'(busy), 0);
      chk("zero_fetch_req", int'(fetch_req), 0);
      @(posedge clk); #1;
    end
    wait_done();

    // address wrap-around
    run_job(3, 'h3FE, 'h001, 1, 'h3FF, 1'b1);

    // abort in the second fetch
    start_job(4, 'h100, 'h180, 2, 3, 1'b1);
    while (cyc < last_t0 + 3) begin
      @(posedge clk); #1;
    end
    chk("abort_in_fetch", int'(fetch_req), 1);
    chk("abort_macs_left", mac_q.size(), 3);
    abort = 1'b1;
    mac_q.delete();
    done_q.delete();
    exp_rv_cyc = -1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_fetch_req", int'(fetch_req), 0);
    repeat (6) @(posedge clk);
    #1;
    run_job(2, 'h050, 'h060, 4, 4, 1'b1);

    // result held in OUT while start pulses are ignored
    rdy_mode = 2;
    rdy_manual = 1'b0;
    start_job(2, 'h020, 'h030, 1, 2, 1'b0);
    n = 0;
    while (!result_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_reached", int'(result_valid), 1);
    repeat (5) begin
      start = 1'b1;
      k_tiles = KW'($urandom);
      chk("out_hold_valid", int'(result_valid), 1);
      chk("out_hold_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rdy_manual = 1'b1;
    wait_done();
    rdy_mode = 0;

    // reset mid-job discards it
    start_job(5, 'h070, 'h080, 3, 5, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    mac_q.delete();
    done_q.delete();
    exp_rv_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_job(1, 'h011, 'h022, 7, 7, 1'b1);

    // randomized handshakes and ignored mid-job starts
    ack_mode = 1;
    rdy_mode = 1;
    noise = 1'b1;
    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(8, 1), $urandom % 1024, $urandom % 1024,
              $urandom % 1024, $urandom % 1024, 1'b0);
    end
    noise = 1'b0;
    ack_mode = 0;
    rdy_mode = 0;

    // maximum tile count
    run_job(255, $urandom % 1024, $urandom % 1024, $urandom % 1024, $urandom % 1024, 1'b1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
